// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared types and encodings for the multicycle MIPS controller.
//   state_e      4-bit FSM state encoding (also exported on the debug port)
//   OP_*         opcode field values recognised in DECODE
//   ALUOP_*, PCSRC_*, SRCB_*  datapath mux / ALU control encodings
package multicycle_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWr  = 4'd4,
    StMemWb  = 4'd5,
    StREx    = 4'd6,
    StRWb    = 4'd7,
    StAddiEx = 4'd8,
    StAddiWb = 4'd9,
    StBeq    = 4'd10,
    StJump   = 4'd11,
    StHalt   = 4'd12,
    StError  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // States that wait on the memory handshake and are guarded by the watchdog.
  function automatic logic is_mem_wait(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// mc_wait_counter: memory-handshake watchdog.
//   clk, rst  clock, synchronous active-high reset
//   clr       restart the count (takes priority over en)
//   en        a wait cycle: memory not ready in a waiting state
//   expired   this wait cycle brings the count to MAX_WAIT
module mc_wait_counter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] Last = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Gated by en, so a completing access in the final cycle never expires.
  assign expired = en && (cnt_q == Last);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing MIPS instructions over the multicycle datapath.
//   clk, rst      clock, synchronous active-high reset
//   opcode        IR[31:26], sampled in DECODE only
//   mem_ready     memory completes the current access this cycle
//   PCWrite .. RegDst, PCSource, ALUSrcB, ALUOp, addi   datapath controls
//   HLT, err      sticky halt / trap flags
//   state         current state for debug
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int unsigned OPW      = 6,
  parameter int unsigned ALUOPW   = 2,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              MemtoReg,
  output logic              ALUSrcA,
  output logic              RegWrite,
  output logic              RegDst,
  output logic [1:0]        PCSource,
  output logic [1:0]        ALUSrcB,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              addi,
  output logic              HLT,
  output logic              err,
  output logic [3:0]        state
);

  state_e state_q, state_d;
  // lw/sw choice latched in DECODE so later opcode changes cannot redirect MEM_ADR.
  logic   is_store_q, is_store_d;
  logic   expired;

  mc_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_d != state_q),
    .en     (is_mem_wait(state_q) && !mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (expired) state_d = StError;
      end
      StDecode: begin
        is_store_d = (opcode == OPW'(OP_SW));
        case (opcode)
          OPW'(OP_RTYPE):          state_d = StREx;
          OPW'(OP_ADDI):           state_d = StAddiEx;
          OPW'(OP_LW), OPW'(OP_SW): state_d = StMemAdr;
          OPW'(OP_BEQ):            state_d = StBeq;
          OPW'(OP_J):              state_d = StJump;
          OPW'(OP_HLT):            state_d = StHalt;
          default:                 state_d = StError;
        endcase
      end
      StMemAdr: state_d = is_store_q ? StMemWr : StMemRd;
      StMemRd: begin
        if (mem_ready)    state_d = StMemWb;
        else if (expired) state_d = StError;
      end
      StMemWr: begin
        if (mem_ready)    state_d = StFetch;
        else if (expired) state_d = StError;
      end
      StREx:    state_d = StRWb;
      StAddiEx: state_d = StAddiWb;
      StRWb, StAddiWb, StMemWb, StBeq, StJump: state_d = StFetch;
      StHalt, StError: state_d = state_q;
      default: state_d = StError;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOPW'(ALUOP_ADD);
    addi        = 1'b0;
    HLT         = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // IR and PC load only on the cycle the fetch completes.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: ALUSrcB = SRCB_IMM_SH2;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StREx: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOPW'(ALUOP_FUNCT);
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOPW'(ALUOP_FUNCT);
        addi    = 1'b1;
      end
      StAddiWb: RegWrite = 1'b1;
      StBeq: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOPW'(ALUOP_SUB);
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      StHalt:  HLT = 1'b1;
      StError: err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench: instruction-level reference model. Each instruction is expanded into its
// list of states (with memory waits, timeouts, halts, traps and resets), expected
// outputs per cycle are queued as stimulus is driven, and a negedge monitor compares.
module tb_multicycle_control;
  import multicycle_pkg::*;

  localparam int MaxWait = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegWrite, RegDst, addi, HLT, err;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  multicycle_control #(
    .OPW(6), .ALUOPW(2), .MAX_WAIT(MaxWait)
  ) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .addi(addi), .HLT(HLT), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst;
    logic [1:0] pcs, srcb, aluop;
    logic addi, hlt, err;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    state_e st;
    bit     mr;
  } cyc_t;

  vec_t expq[$];
  cyc_t plan[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  vec_t act;

  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, addi, HLT, err, state};

  // Control values each state must present, straight from the state table.
  function automatic vec_t exp_vec(state_e s, bit mr);
    vec_t v;
    v = '0;
    v.st = s;
    case (s)
      StFetch: begin v.mrd = 1; v.srcb = 2'b01; v.irw = mr; v.pcw = mr; end
      StDecode: v.srcb = 2'b11;
      StMemAdr: begin v.srca = 1; v.srcb = 2'b10; end
      StMemRd:  begin v.mrd = 1; v.iord = 1; end
      StMemWr:  begin v.mwr = 1; v.iord = 1; end
      StMemWb:  begin v.rw = 1; v.m2r = 1; end
      StREx:    begin v.srca = 1; v.aluop = 2'b10; end
      StRWb:    begin v.rw = 1; v.rdst = 1; end
      StAddiEx: begin v.srca = 1; v.srcb = 2'b10; v.aluop = 2'b10; v.addi = 1; end
      StAddiWb: v.rw = 1;
      StBeq:    begin v.srca = 1; v.aluop = 2'b01; v.pcwc = 1; v.pcs = 2'b01; end
      StJump:   begin v.pcw = 1; v.pcs = 2'b10; end
      StHalt:   v.hlt = 1;
      StError:  v.err = 1;
      default: ;
    endcase
    return v;
  endfunction

  // A memory phase with w wait cycles; w >= MaxWait means the watchdog fires.
  task automatic add_mem(input state_e s, input int w, output bit dead);
    cyc_t c;
    c.st = s;
    dead = (w >= MaxWait);
    c.mr = 1'b0;
    repeat (dead ? MaxWait : w) plan.push_back(c);
    if (!dead) begin
      c.mr = 1'b1;
      plan.push_back(c);
    end
  endtask

  task automatic add_st(input state_e s);
    cyc_t c;
    c.st = s;
    c.mr = 1'b0;
    plan.push_back(c);
  endtask

  // Run one instruction: fetch waits wf, data-memory waits wm, hold cycles in a
  // terminal state, and optional reset at plan index rst_at (-1 = none).
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int hold,
                           input int rst_at);
    bit dead;
    int n;
    int ra;
    bit is_rst;
    plan.delete();
    ra = rst_at;
    add_mem(StFetch, wf, dead);
    if (!dead) begin
      add_st(StDecode);
      case (op)
        OP_RTYPE: begin add_st(StREx); add_st(StRWb); end
        OP_ADDI:  begin add_st(StAddiEx); add_st(StAddiWb); end
        OP_LW: begin
          add_st(StMemAdr);
          add_mem(StMemRd, wm, dead);
          if (!dead) add_st(StMemWb);
        end
        OP_SW: begin add_st(StMemAdr); add_mem(StMemWr, wm, dead); end
        OP_BEQ:   add_st(StBeq);
        OP_J:     add_st(StJump);
        OP_HLT:   repeat (hold) add_st(StHalt);
        default:  dead = 1'b1;
      endcase
    end
    if (dead) repeat (hold) add_st(StError);
    n = plan.size();
    if ((plan[n-1].st == StHalt || plan[n-1].st == StError) && (ra < 0 || ra >= n)) ra = n - 1;
    for (int i = 0; i < n; i++) begin
      is_rst = (i == ra);
      rst = is_rst;
      opcode = (plan[i].st == StDecode) ? op : 6'($urandom);
      mem_ready = is_mem_wait(plan[i].st) ? plan[i].mr : 1'($urandom);
      expq.push_back(exp_vec(plan[i].st, mem_ready));
      @(posedge clk);
      #1;
      if (is_rst) break;
    end
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle %0d controls: got %h (state %0d) expected %h (state %0d)",
                 cyc, act, act.st, e, e.st);
      end
      cyc++;
    end
  end

  initial begin
    logic [5:0] op;
    int k;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Reset taken in R_WB, then normal instruction flow.
    run_instr(OP_RTYPE, 0, 0, 1, 3);
    run_instr(OP_LW, 0, 0, 1, -1);
    run_instr(OP_SW, 0, 3, 1, -1);
    run_instr(OP_BEQ, 0, 0, 1, -1);
    run_instr(OP_J, 0, 0, 1, -1);
    run_instr(OP_ADDI, 1, 0, 1, -1);
    // Watchdog: timeout in FETCH, then completion on the last allowed cycle.
    run_instr(OP_RTYPE, MaxWait, 0, 5, -1);
    run_instr(OP_RTYPE, MaxWait - 1, 0, 1, -1);
    run_instr(OP_LW, 0, MaxWait, 3, -1);
    run_instr(OP_SW, 2, MaxWait - 1, 1, -1);
    run_instr(6'b010101, 0, 0, 3, -1);
    run_instr(OP_HLT, 0, 0, 20, -1);
    for (int it = 0; it < 300; it++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: op = OP_RTYPE;
        1: op = OP_ADDI;
        2, 8: op = OP_LW;
        3, 9: op = OP_SW;
        4: op = OP_BEQ;
        5: op = OP_J;
        6: op = OP_HLT;
        default: begin
          op = 6'($urandom);
          while (op == OP_RTYPE || op == OP_ADDI || op == OP_LW || op == OP_SW ||
                 op == OP_BEQ || op == OP_J || op == OP_HLT) op = 6'($urandom);
        end
      endcase
      run_instr(op,
                ($urandom_range(0, 7) == 0) ? MaxWait : $urandom_range(0, MaxWait - 1),
                ($urandom_range(0, 7) == 0) ? MaxWait : $urandom_range(0, MaxWait - 1),
                $urandom_range(1, 4),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences MIPS instructions over 3–5 cycles, sharing one ALU and one memory port. It sits between the instruction register's opcode field and the multicycle datapath (PC, IR, MDR, A/B, ALUOut registers). It adds a variable-latency memory handshake with watchdog timeout, a sticky halt, and an illegal-opcode trap.

## Interface
- `OPW`, default 6: opcode width.
- `ALUOPW`, default 2: ALUOp width.
- `MAX_WAIT`, default 15: maximum cycles to wait for `mem_ready` before timeout; must be ≥1.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `opcode`  in  OPW: IR[31:26]; valid from the DECODE state onward.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each: multicycle datapath controls.
- `PCSource`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUSrcB`  out  2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `ALUOp`  out  ALUOPW: 00 = add, 01 = subtract, 10 = funct field.
- `addi`  out  1: asserted in ADDI_EX; forces add regardless of funct.
- `HLT`  out  1: processor halted (sticky).
- `err`  out  1: trap flag (sticky); set by an illegal opcode or a memory timeout.
- `state`  out  4: current state encoding, for debug and the bench.

## Operation
States and transitions:
- FETCH: stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE, by opcode:
  - `000000` → R_EX
  - `001000` → ADDI_EX
  - `100011` or `101011` → MEM_ADR
  - `000100` → BEQ
  - `000010` → JUMP
  - `111111` → HALT
  - any other opcode → ERROR
- MEM_ADR: goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: waits for `mem_ready`, then goes to MEM_WB.
- MEM_WR: waits for `mem_ready`, then goes to FETCH.
- R_EX → R_WB → FETCH.
- ADDI_EX → ADDI_WB → FETCH.
- MEM_WB, BEQ and JUMP each go to FETCH.
- HALT and ERROR are absorbing; only `rst` leaves them.

Outputs are Moore per state. Every signal not listed for a state is 0.
- FETCH:
  - Always: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - Only in the cycle `mem_ready`=1 (Mealy): `IRWrite`=1, `PCWrite`=1.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00.
- MEM_ADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
- MEM_RD: `MemRead`=1, `IorD`=1.
- MEM_WR: `MemWrite`=1, `IorD`=1.
- MEM_WB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
- R_EX: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
- R_WB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
- ADDI_EX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=10, `addi`=1.
- ADDI_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
- BEQ: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
- JUMP: `PCWrite`=1, `PCSource`=10.
- HALT: `HLT`=1.
- ERROR: `err`=1.

Wait counter:
- Clears on entry to FETCH, MEM_RD and MEM_WR.
- Increments each cycle `mem_ready`=0 in those states.
- If it reaches `MAX_WAIT` with `mem_ready` still 0, the next state is ERROR.
- If `mem_ready`=1 in the same cycle the count reaches `MAX_WAIT`, completion wins: no error.
- Counter width is $clog2(MAX_WAIT+1).

## Timing
- On reset (`rst`=1 at a clock edge), from the next cycle:
  - state = FETCH; wait counter = 0.
  - `HLT`=0, `err`=0.
  - All other outputs take their FETCH values; write enables stay 0 until `mem_ready`.
- Reset mid-instruction (including HALT or ERROR) discards the instruction; no write enable is asserted in the reset cycle's successor unless FETCH sees `mem_ready`.
- With zero-wait memory (`mem_ready` held 1), each instruction takes:
  - beq 3 cycles, j 3, R-type 4, addi 4, sw 4, lw 5.
  - Each extra wait cycle adds exactly 1 cycle.
- `opcode` is sampled only in DECODE; changes in other states are ignored.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.

## Structure
- Package `multicycle_pkg` holds:
  - the state enum (4-bit encoding);
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HLT;
  - ALUOp, PCSource and ALUSrcB encodings.
- Sub-module `mc_wait_counter` (ports: `clk`, `rst`, `clr`, `en`, `expired`) implements the parameterised watchdog.
- The top level contains only the state register, the next-state logic and the output decode.

## Test plan
- Reset mid-stream: `rst` in R_WB → `state`=FETCH next cycle; `RegWrite`=0; `HLT`=0; `err`=0.
- lw with `mem_ready`=1 throughout → states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB in 5 cycles; `RegWrite`=1 and `MemtoReg`=1 only in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEM_WR → `MemWrite` held 4 cycles; back to FETCH after 7 cycles total.
- Watchdog with `MAX_WAIT`=4: `mem_ready`=0 forever in FETCH → ERROR after 4 cycles, `err`=1 sticky. Repeat with `mem_ready`=1 on the 4th cycle → DECODE, `err`=0.
- Opcode 6'b010101 → ERROR from DECODE. Opcode 6'b111111 → HALT, `HLT`=1 held for 20 cycles until `rst`.
- beq then j back-to-back → `PCWriteCond`=1 with `PCSource`=01 in cycle 3; `PCWrite`=1 with `PCSource`=10 in cycle 6.
